// File: rtl/cache_ri_refill.sv
// cache_ri_refill -- line-refill engine for the data cache readable-bit store.
//
// On a refill request the engine claims the readable-bit store (sel), then
// walks the line one pair of words at a time:
//   RD_DRE -> CAP -> CHK [-> MEM -> WR_DATA] ... -> WR_DRE
// For every word that needs a fetch, it reads the word from memory and writes
// the data RAM only at bytes whose readable bit is still 0. Each pair is then
// marked fully readable (8'hFF). DONE pulses once after the last pair.
//
// Optional feature macro: CACHE_RI_SKIP_VALID_EN
//   defined   : words whose four readable bits are all set are not fetched.
//   undefined : every word is fetched; fully readable words get data_wbe=4'h0.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready == engine idle)
//   req_line/req_channel            line index and way to refill
//   req_mem_base                    memory word address of line word 0
//   done                            one-cycle completion pulse
//   sel                             claims the readable-bit store (ri over rw)
//   ri_read*/ri_write*              readable-bit store read/write port
//   mem_req/mem_addr/mem_ack/mem_rdata  memory read channel
//   data_*                          data RAM write port
// All outputs are registered.

module cache_ri_refill #(
  parameter int ADDR_WIDTH = 9,
  parameter int LINE_WORDS = 8,
  parameter int MEM_AW     = 30
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0] req_line,
  input  logic [1:0]                              req_channel,
  input  logic [MEM_AW-1:0]                       req_mem_base,
  output logic                                    done,
  output logic                                    sel,
  output logic [ADDR_WIDTH-1:0]                   ri_readAddress,
  output logic [1:0]                              ri_readChannel,
  input  logic [7:0]                              ri_readData,
  output logic [ADDR_WIDTH-1:0]                   ri_writeAddress,
  output logic [1:0]                              ri_writeChannel,
  output logic                                    ri_writeEnable,
  output logic [7:0]                              ri_writeData,
  output logic                                    mem_req,
  output logic [MEM_AW-1:0]                       mem_addr,
  input  logic                                    mem_ack,
  input  logic [31:0]                             mem_rdata,
  output logic                                    data_we,
  output logic [ADDR_WIDTH-1:0]                   data_waddr,
  output logic [1:0]                              data_wchannel,
  output logic [31:0]                             data_wdata,
  output logic [3:0]                              data_wbe
);

  localparam int LW = $clog2(LINE_WORDS);
  localparam int LA = ADDR_WIDTH - LW;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_DRE  = 3'd1,
    S_CAP     = 3'd2,
    S_CHK     = 3'd3,
    S_MEM     = 3'd4,
    S_WR_DATA = 3'd5,
    S_WR_DRE  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t r_state, w_state_nxt;

  // Working registers: latched request, word index {p, w}, captured readable bits
  logic [LA-1:0]     r_line, w_line_nxt;
  logic [1:0]        r_chan, w_chan_nxt;
  logic [MEM_AW-1:0] r_base, w_base_nxt;
  logic [LW-1:0]     r_widx, w_widx_nxt;
  logic [7:0]        r_re8,  w_re8_nxt;

  // Output registers
  logic                  r_req_ready, r_done, r_sel;
  logic [ADDR_WIDTH-1:0] r_ri_raddr, w_ri_raddr_nxt;
  logic [1:0]            r_ri_rchan, w_ri_rchan_nxt;
  logic [ADDR_WIDTH-1:0] r_ri_waddr, w_ri_waddr_nxt;
  logic [1:0]            r_ri_wchan, w_ri_wchan_nxt;
  logic                  r_ri_we,    w_ri_we_nxt;
  logic [7:0]            r_ri_wdata, w_ri_wdata_nxt;
  logic                  r_mem_req,  w_mem_req_nxt;
  logic [MEM_AW-1:0]     r_mem_addr, w_mem_addr_nxt;
  logic                  r_data_we,  w_data_we_nxt;
  logic [ADDR_WIDTH-1:0] r_data_waddr, w_data_waddr_nxt;
  logic [1:0]            r_data_wchan, w_data_wchan_nxt;
  logic [31:0]           r_data_wdata, w_data_wdata_nxt;
  logic [3:0]            r_data_wbe,   w_data_wbe_nxt;
  logic                  w_done_nxt;
  logic                  w_sel_nxt;
  logic                  w_ready_nxt;

  logic [3:0]            w_re4;
  logic                  w_need_fetch;
  logic [LW-1:0]         w_widx_inc;
  logic [ADDR_WIDTH-1:0] w_pair_addr;
  logic                  w_last_pair;

  // Readable bits of the word currently examined: bit0 of the index picks the nibble
  assign w_re4       = r_widx[0] ? r_re8[7:4] : r_re8[3:0];
  assign w_widx_inc  = r_widx + LW'(1);
  assign w_pair_addr = {r_line, r_widx & ~LW'(1)};
  assign w_last_pair = ((r_widx | LW'(1)) == LW'(LINE_WORDS - 1));

`ifdef CACHE_RI_SKIP_VALID_EN
  assign w_need_fetch = (w_re4 != 4'hF);
`else
  assign w_need_fetch = 1'b1;
`endif

  // Outputs are registered from the next state, so they line up with the state they belong to
  assign w_sel_nxt   = (w_state_nxt != S_IDLE);
  assign w_ready_nxt = (w_state_nxt == S_IDLE);

  // Next-state, datapath and next-output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_line_nxt       = r_line;
    w_chan_nxt       = r_chan;
    w_base_nxt       = r_base;
    w_widx_nxt       = r_widx;
    w_re8_nxt        = r_re8;
    w_ri_raddr_nxt   = r_ri_raddr;
    w_ri_rchan_nxt   = r_ri_rchan;
    w_ri_waddr_nxt   = r_ri_waddr;
    w_ri_wchan_nxt   = r_ri_wchan;
    w_ri_wdata_nxt   = r_ri_wdata;
    w_ri_we_nxt      = 1'b0;
    w_mem_req_nxt    = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_data_we_nxt    = 1'b0;
    w_data_waddr_nxt = r_data_waddr;
    w_data_wchan_nxt = r_data_wchan;
    w_data_wdata_nxt = r_data_wdata;
    w_data_wbe_nxt   = r_data_wbe;
    w_done_nxt       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_state_nxt    = S_RD_DRE;
          w_line_nxt     = req_line;
          w_chan_nxt     = req_channel;
          w_base_nxt     = req_mem_base;
          w_widx_nxt     = {LW{1'b0}};
          w_ri_raddr_nxt = {req_line, {LW{1'b0}}};
          w_ri_rchan_nxt = req_channel;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_RD_DRE: begin
        w_state_nxt = S_CAP;
      end

      S_CAP: begin
        w_re8_nxt   = ri_readData;
        w_widx_nxt  = r_widx & ~LW'(1);
        w_state_nxt = S_CHK;
      end

      S_CHK: begin
        if (w_need_fetch) begin
          w_state_nxt    = S_MEM;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = r_base + MEM_AW'(r_widx);
        end else if (!r_widx[0]) begin
          w_widx_nxt  = r_widx | LW'(1);
          w_state_nxt = S_CHK;
        end else begin
          w_state_nxt    = S_WR_DRE;
          w_ri_we_nxt    = 1'b1;
          w_ri_waddr_nxt = w_pair_addr;
          w_ri_wchan_nxt = r_chan;
          w_ri_wdata_nxt = 8'hFF;
        end
      end

      S_MEM: begin
        // mem_rdata is latched straight into the data-RAM write register
        if (mem_ack) begin
          w_state_nxt      = S_WR_DATA;
          w_data_we_nxt    = 1'b1;
          w_data_waddr_nxt = {r_line, r_widx};
          w_data_wchan_nxt = r_chan;
          w_data_wdata_nxt = mem_rdata;
          w_data_wbe_nxt   = ~w_re4;
        end else begin
          w_mem_req_nxt = 1'b1;
        end
      end

      S_WR_DATA: begin
        if (!r_widx[0]) begin
          w_widx_nxt  = r_widx | LW'(1);
          w_state_nxt = S_CHK;
        end else begin
          w_state_nxt    = S_WR_DRE;
          w_ri_we_nxt    = 1'b1;
          w_ri_waddr_nxt = w_pair_addr;
          w_ri_wchan_nxt = r_chan;
          w_ri_wdata_nxt = 8'hFF;
        end
      end

      S_WR_DRE: begin
        if (w_last_pair) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt    = S_RD_DRE;
          w_widx_nxt     = w_widx_inc;
          w_ri_raddr_nxt = {r_line, w_widx_inc};
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs; reset drops every strobe immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line       <= {LA{1'b0}};
      r_chan       <= 2'b00;
      r_base       <= {MEM_AW{1'b0}};
      r_widx       <= {LW{1'b0}};
      r_re8        <= 8'h00;
      r_req_ready  <= 1'b1;
      r_done       <= 1'b0;
      r_sel        <= 1'b0;
      r_ri_raddr   <= {ADDR_WIDTH{1'b0}};
      r_ri_rchan   <= 2'b00;
      r_ri_waddr   <= {ADDR_WIDTH{1'b0}};
      r_ri_wchan   <= 2'b00;
      r_ri_we      <= 1'b0;
      r_ri_wdata   <= 8'h00;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= {MEM_AW{1'b0}};
      r_data_we    <= 1'b0;
      r_data_waddr <= {ADDR_WIDTH{1'b0}};
      r_data_wchan <= 2'b00;
      r_data_wdata <= 32'h0000_0000;
      r_data_wbe   <= 4'h0;
    end else begin
      r_line       <= w_line_nxt;
      r_chan       <= w_chan_nxt;
      r_base       <= w_base_nxt;
      r_widx       <= w_widx_nxt;
      r_re8        <= w_re8_nxt;
      r_req_ready  <= w_ready_nxt;
      r_done       <= w_done_nxt;
      r_sel        <= w_sel_nxt;
      r_ri_raddr   <= w_ri_raddr_nxt;
      r_ri_rchan   <= w_ri_rchan_nxt;
      r_ri_waddr   <= w_ri_waddr_nxt;
      r_ri_wchan   <= w_ri_wchan_nxt;
      r_ri_we      <= w_ri_we_nxt;
      r_ri_wdata   <= w_ri_wdata_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_data_we    <= w_data_we_nxt;
      r_data_waddr <= w_data_waddr_nxt;
      r_data_wchan <= w_data_wchan_nxt;
      r_data_wdata <= w_data_wdata_nxt;
      r_data_wbe   <= w_data_wbe_nxt;
    end
  end

  assign req_ready       = r_req_ready;
  assign done            = r_done;
  assign sel             = r_sel;
  assign ri_readAddress  = r_ri_raddr;
  assign ri_readChannel  = r_ri_rchan;
  assign ri_writeAddress = r_ri_waddr;
  assign ri_writeChannel = r_ri_wchan;
  assign ri_writeEnable  = r_ri_we;
  assign ri_writeData    = r_ri_wdata;
  assign mem_req         = r_mem_req;
  assign mem_addr        = r_mem_addr;
  assign data_we         = r_data_we;
  assign data_waddr      = r_data_waddr;
  assign data_wchannel   = r_data_wchan;
  assign data_wdata      = r_data_wdata;
  assign data_wbe        = r_data_wbe;

endmodule

// File: tb/tb_cache_ri_refill.sv
// Testbench for cache_ri_refill: table of refill scenarios (readable-bit
// pattern, memory latency, hand-computed fetch mask / byte enables / done
// cycle for both builds of CACHE_RI_SKIP_VALID_EN), plus a hand-written
// reset-in-the-middle-of-MEM sequence.

module tb_cache_ri_refill;

  localparam int AW = 9;
  localparam int LA = 6;
  localparam int MAW = 30;

`ifdef CACHE_RI_SKIP_VALID_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [LA-1:0]  req_line;
  logic [1:0]     req_channel;
  logic [MAW-1:0] req_mem_base;
  logic           done;
  logic           sel;
  logic [AW-1:0]  ri_readAddress;
  logic [1:0]     ri_readChannel;
  logic [7:0]     ri_readData;
  logic [AW-1:0]  ri_writeAddress;
  logic [1:0]     ri_writeChannel;
  logic           ri_writeEnable;
  logic [7:0]     ri_writeData;
  logic           mem_req;
  logic [MAW-1:0] mem_addr;
  logic           mem_ack;
  logic [31:0]    mem_rdata;
  logic           data_we;
  logic [AW-1:0]  data_waddr;
  logic [1:0]     data_wchannel;
  logic [31:0]    data_wdata;
  logic [3:0]     data_wbe;

  cache_ri_refill dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_line(req_line), .req_channel(req_channel), .req_mem_base(req_mem_base),
    .done(done), .sel(sel),
    .ri_readAddress(ri_readAddress), .ri_readChannel(ri_readChannel), .ri_readData(ri_readData),
    .ri_writeAddress(ri_writeAddress), .ri_writeChannel(ri_writeChannel),
    .ri_writeEnable(ri_writeEnable), .ri_writeData(ri_writeData),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .data_we(data_we), .data_waddr(data_waddr), .data_wchannel(data_wchannel),
    .data_wdata(data_wdata), .data_wbe(data_wbe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LA-1:0]  line;
    logic [1:0]     chan;
    logic [MAW-1:0] base;
    logic [31:0]    re;        // pair i readable bits at [8i+7:8i]
    int             lat;       // MEM cycles per fetch
    logic [31:0]    wbe;       // expected data_wbe of word i at [4i+3:4i]
    logic [7:0]     fm_skip;   // fetched words, skip build
    logic [7:0]     fm_ns;     // fetched words, default build
    int             done_skip; // done cycle after accept, skip build
    int             done_ns;
  } vec_t;

  vec_t vecs [6];

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one refill; with abort_en it asserts reset in the 3rd MEM cycle of word 4
  task automatic run_vec(input vec_t v, input bit abort_en, input int id);
    int       cyc;
    bit       seen_done;
    bit       aborted;
    bit       rd_valid;
    logic [1:0] rd_pair;
    int       mem_cnt;
    bit       prev_req, prev_ack;
    logic [MAW-1:0] prev_addr;
    logic [7:0] fmask, dmask;
    logic [3:0] pmask;
    int       n_fetch, n_dwe, n_rwe;
    logic [MAW-1:0] woff;
    int       w;
    seen_done = 1'b0; aborted = 1'b0; rd_valid = 1'b0; rd_pair = 2'd0;
    mem_cnt = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    fmask = 8'h00; dmask = 8'h00; pmask = 4'h0; n_fetch = 0; n_dwe = 0; n_rwe = 0;

    @(negedge clk);
    chk($sformatf("v%0d_ready_idle", id), req_ready, 1'b1);
    req_valid = 1'b1; req_line = v.line; req_channel = v.chan; req_mem_base = v.base;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < 400 && !seen_done && !aborted) begin
      // observe outputs of this cycle
      if (!sel) chk($sformatf("v%0d_sel_c%0d", id, cyc), sel, 1'b1);
      if (data_we) begin
        w = int'(data_waddr[2:0]);
        n_dwe++;
        dmask[w] = 1'b1;
        chk($sformatf("v%0d_dwaddr_line", id), data_waddr[AW-1:3], v.line);
        chk($sformatf("v%0d_dwchan", id), data_wchannel, v.chan);
        chk($sformatf("v%0d_dwdata_w%0d", id, w), data_wdata, 32'hA000_0000 + w);
        chk($sformatf("v%0d_wbe_w%0d", id, w), data_wbe, v.wbe[4*w +: 4]);
      end
      if (ri_writeEnable) begin
        n_rwe++;
        pmask[ri_writeAddress[2:1]] = 1'b1;
        chk($sformatf("v%0d_riw_addr", id), {ri_writeAddress[AW-1:3], ri_writeAddress[0]}, {v.line, 1'b0});
        chk($sformatf("v%0d_riw_chan", id), ri_writeChannel, v.chan);
        chk($sformatf("v%0d_riw_data", id), ri_writeData, 8'hFF);
      end
      if (done) seen_done = 1'b1;
      if (prev_ack) chk($sformatf("v%0d_mem_req_drop", id), mem_req, 1'b0);
      if (mem_req && prev_req && !prev_ack)
        chk($sformatf("v%0d_mem_addr_stable", id), mem_addr, prev_addr);

      // readable-bit store: one-cycle read latency
      ri_readData = rd_valid ? v.re[8*rd_pair +: 8] : 8'h5A;
      rd_valid = sel;
      rd_pair = ri_readAddress[2:1];

      // memory: ack after lat MEM cycles; spurious acks while idle
      prev_req = mem_req;
      prev_addr = mem_addr;
      if (mem_req) begin
        mem_cnt++;
        woff = mem_addr - v.base;
        mem_ack = (mem_cnt == v.lat);
        mem_rdata = 32'hA000_0000 + woff[31:0];
        if (mem_ack) begin
          n_fetch++;
          if (woff < 8) fmask[woff[2:0]] = 1'b1;
          else chk($sformatf("v%0d_mem_addr_range", id), woff, 30'd0);
        end
        if (abort_en && woff == 30'd4 && mem_cnt == 3) aborted = 1'b1;
      end else begin
        mem_cnt = 0;
        mem_ack = cyc[0];
        mem_rdata = 32'hDEAD_BEEF;
      end
      prev_ack = mem_ack && mem_req;

      if (!seen_done && !aborted) begin
        @(negedge clk);
        cyc++;
      end
    end

    if (aborted) begin
      rst_n = 1'b0;
      mem_ack = 1'b0;
      #1;
      chk("rst_mid_sel", sel, 1'b0);
      chk("rst_mid_mem_req", mem_req, 1'b0);
      chk("rst_mid_ready", req_ready, 1'b1);
      chk("rst_mid_data_we", data_we, 1'b0);
      chk("rst_mid_ri_we", ri_writeEnable, 1'b0);
      chk("rst_mid_done", done, 1'b0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (data_we || ri_writeEnable) begin
          chk("rst_mid_no_write", {data_we, ri_writeEnable}, 2'b00);
        end
      end
      chk("rst_mid_pairs_written", pmask, 4'b0011);
      chk("rst_mid_words_written", dmask, 8'h0F);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("post_rst_idle", {sel, mem_req, data_we, ri_writeEnable, req_ready}, 5'b00001);
      end
    end else begin
      chk($sformatf("v%0d_done_seen", id), seen_done, 1'b1);
      chk($sformatf("v%0d_done_cycle", id), cyc, SKIP ? v.done_skip : v.done_ns);
      chk($sformatf("v%0d_fetch_mask", id), fmask, SKIP ? v.fm_skip : v.fm_ns);
      chk($sformatf("v%0d_fetch_count", id), n_fetch, SKIP ? $countones(v.fm_skip) : $countones(v.fm_ns));
      chk($sformatf("v%0d_data_we_mask", id), dmask, SKIP ? v.fm_skip : v.fm_ns);
      chk($sformatf("v%0d_data_we_count", id), n_dwe, n_fetch);
      chk($sformatf("v%0d_ri_we_count", id), n_rwe, 4);
      chk($sformatf("v%0d_pair_mask", id), pmask, 4'hF);
      @(negedge clk);
      chk($sformatf("v%0d_ready_after_done", id), req_ready, 1'b1);
      chk($sformatf("v%0d_sel_after_done", id), sel, 1'b0);
      chk($sformatf("v%0d_done_one_pulse", id), done, 1'b0);
    end
  endtask

  initial begin
    vec_t va;
    // empty line: every word fetched with all bytes enabled
    vecs[0] = '{line: 6'h05, chan: 2'd2, base: 30'h0000_1000, re: 32'h0000_0000, lat: 1,
                wbe: 32'hFFFF_FFFF, fm_skip: 8'hFF, fm_ns: 8'hFF, done_skip: 37, done_ns: 37};
    // full line; base wraps modulo 2^30 in the second half of the line
    vecs[1] = '{line: 6'h3F, chan: 2'd1, base: 30'h3FFF_FFFC, re: 32'hFFFF_FFFF, lat: 1,
                wbe: 32'h0000_0000, fm_skip: 8'h00, fm_ns: 8'hFF, done_skip: 21, done_ns: 37};
    // pair 1 = 8'h3C: word2 wbe 3, word3 wbe C
    vecs[2] = '{line: 6'h12, chan: 2'd3, base: 30'h0000_0200, re: 32'hFFFF_3CFF, lat: 1,
                wbe: 32'h0000_C300, fm_skip: 8'h0C, fm_ns: 8'hFF, done_skip: 25, done_ns: 37};
    // only word 0 empty, 1-cycle ack
    vecs[3] = '{line: 6'h01, chan: 2'd0, base: 30'h0000_0040, re: 32'hFFFF_FFF0, lat: 1,
                wbe: 32'h0000_000F, fm_skip: 8'h01, fm_ns: 8'hFF, done_skip: 23, done_ns: 37};
    // same with a 10-cycle MEM stall: 9 cycles later per fetch
    vecs[4] = '{line: 6'h01, chan: 2'd0, base: 30'h0000_0040, re: 32'hFFFF_FFF0, lat: 10,
                wbe: 32'h0000_000F, fm_skip: 8'h01, fm_ns: 8'hFF, done_skip: 32, done_ns: 109};
    // mixed: pair0 1E, pair2 00, 2-cycle memory
    vecs[5] = '{line: 6'h2A, chan: 2'd2, base: 30'h0123_4560, re: 32'hFF00_FF1E, lat: 2,
                wbe: 32'h00FF_00E1, fm_skip: 8'h33, fm_ns: 8'hFF, done_skip: 33, done_ns: 45};

    rst_n = 1'b0; req_valid = 1'b0; req_line = '0; req_channel = 2'd0; req_mem_base = '0;
    ri_readData = 8'h00; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_strobes", {sel, done, mem_req, data_we, ri_writeEnable}, 5'b00000);
    chk("rst_ri_addr", {ri_readAddress, ri_readChannel, ri_writeAddress, ri_writeChannel, ri_writeData}, 34'h0);
    chk("rst_mem_addr", mem_addr, 30'h0);
    chk("rst_data_bus", {data_waddr, data_wchannel, data_wbe}, 15'h0);
    chk("rst_data_wdata", data_wdata, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0, i);

    // reset while pair 2 waits in MEM, then a normal refill
    va = vecs[0];
    va.lat = 20;
    run_vec(va, 1'b1, 10);
    run_vec(vecs[2], 1'b0, 11);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_ri_refill.md
# cache_ri_refill

Line-refill engine that drives the `ri` port of the per-byte readable-bit store of the data cache. On a miss it claims the store through `sel` and walks the line two words at a time, reading each pair's readable bits. For every word that is not fully readable, it fetches the word from memory and writes the data RAM only at bytes the CPU has not already written. It then marks the pair fully readable (8'hFF). It sits between the cache controller, the readable-bit store and the memory bus master.

## Interface
- `ADDR_WIDTH`, 9: word address width of the readable-bit store and data RAM.
- `LINE_WORDS`, 8: words per cache line; power of two, ≥2.
- `MEM_AW`, 30: memory word-address width.

Ports:
- `clk` input 1: clock; single clock domain.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: refill request.
- `req_ready` output 1: engine idle; a request is accepted when `req_valid && req_ready`.
- `req_line` input ADDR_WIDTH-log2(LINE_WORDS): line index.
- `req_channel` input 2: way.
- `req_mem_base` input MEM_AW: memory word address of line word 0.
- `done` output 1: one-cycle pulse when the refill is complete.
- `sel` output 1: selects `ri` over `rw` at the readable-bit store.
- `ri_readAddress` output ADDR_WIDTH: read address; bit0 is always 0.
- `ri_readChannel` output 2: read way.
- `ri_readData` input 8: readable bits of the addressed pair, valid 1 cycle after the address. Bits [3:0] belong to the even word, bits [7:4] to the odd word.
- `ri_writeAddress` output ADDR_WIDTH: write address.
- `ri_writeChannel` output 2: write way.
- `ri_writeEnable` output 1: write strobe for the readable-bit store.
- `ri_writeData` output 8: readable bits to write.
- `mem_req` output 1: memory read request.
- `mem_addr` output MEM_AW: memory word address.
- `mem_ack` input 1: memory acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata` input 32: read data.
- `data_we` output 1: data RAM write strobe.
- `data_waddr` output ADDR_WIDTH: data RAM word address.
- `data_wchannel` output 2: data RAM way.
- `data_wdata` output 32: data RAM write data.
- `data_wbe` output 4: data RAM byte enables.

## Operation
- **Accept.** The request is accepted in IDLE. The engine latches `req_line`, `req_channel` and `req_mem_base`, clears the pair counter `p`, and deasserts `req_ready`.
- **Word addressing.**
  - Word address = {line, p, w}, where w ∈ {0,1}.
  - `mem_addr` = `req_mem_base` + (2p + w), computed modulo 2^MEM_AW.
- **States** (each state lasts one cycle except MEM):
  - IDLE → RD_DRE on accept.
  - RD_DRE drives `ri_readAddress` = {line, p, 0} and `ri_readChannel` = the latched way → CAP.
  - CAP captures `ri_readData` into `re8` and sets w=0 → CHK.
  - CHK examines `re4` = `re8` nibble w.
    - If the word needs a fetch → MEM.
    - Otherwise, if w=0, set w=1 and stay in CHK; if w=1 → WR_DRE.
  - MEM holds `mem_req` high and `mem_addr` stable until `mem_ack`. On `mem_ack` it latches `mem_rdata` → WR_DATA.
  - WR_DATA pulses `data_we` with `data_wdata` = the latched word and `data_wbe` = ~`re4`. It then moves to CHK with w=1 if w was 0, or to WR_DRE if w was 1.
  - WR_DRE pulses `ri_writeEnable` with `ri_writeAddress` = {line, p, 0} and `ri_writeData` = 8'hFF.
    - If p = LINE_WORDS/2−1 → DONE; otherwise p+1 → RD_DRE.
  - DONE pulses `done` → IDLE.
- **sel.** `sel` = 1 in every state except IDLE. The controller stalls `rw` traffic while `sel` = 1.
- **Byte rule.** Bytes whose readable bit is 1 are never overwritten. If `re4` = 4'h0 then `data_wbe` = 4'hF.
- **Reset.** Asserting `rst_n` at any point, including mid-refill, forces IDLE.
  - All strobes, `sel` and `done` drop to 0 immediately.
  - No further writes occur; pairs already written stay written.
- **Reset values.**
  - `req_ready` = 1.
  - `sel`, `done`, `mem_req`, `data_we`, `ri_writeEnable` = 0.
  - All address, data and enable buses = 0.

## Timing
- Accept occurs at cycle 0, and RD_DRE runs in cycle 1.
- A pair that needs no fetch takes 5 cycles.
- Each fetched word adds (MEM cycles + 1) cycles; MEM lasts at least 1 cycle.
- `done` rises 1 cycle after the last WR_DRE. `req_ready` returns the cycle after `done`.
- A new request can be accepted no earlier than the cycle after `done`.
- `mem_ack` arriving outside MEM is ignored.
- `mem_req` deasserts in the cycle after `mem_ack`.

## Configuration
- Macro `CACHE_RI_SKIP_VALID_EN`.
  - **Defined:** CHK skips the fetch when `re4` = 4'hF.
  - **Undefined:** every word is fetched and written with `data_wbe` = ~`re4`. A fully readable word therefore issues a WR_DATA with `data_wbe` = 4'h0.

## Test plan
- **Empty line, skip enabled.** All readable bits 0, LINE_WORDS=8, `mem_ack` one cycle after each `mem_req`, `mem_rdata` = 0xA0000000+word.
  - Required: 8 memory reads at base+0..7.
  - Required: 8 `data_we` pulses, each with `data_wbe` = 4'hF.
  - Required: 4 `ri_writeEnable` pulses with data 8'hFF.
- **Full line, skip enabled.** All readable bits 8'hFF.
  - Required: no `mem_req`.
  - Required: `done` at cycle 21 after accept.
- **Partial word.** Pair 1 `ri_readData` = 8'h3C, all other pairs full.
  - Required: word 2 written with `data_wbe` = 4'h3.
  - Required: word 3 written with `data_wbe` = 4'hC.
- **Memory stall.** `mem_ack` held low for 10 cycles.
  - Required: `mem_req` and `mem_addr` stable throughout.
  - Required: completion delayed by exactly 9 cycles versus a 1-cycle ack.
- **Reset mid-MEM of pair 2.**
  - Required: `sel` = 0, `mem_req` = 0 and `req_ready` = 1 while reset is asserted.
  - Required: no write to pairs 2–3.
  - Required: the next request completes normally.
- **Skip disabled, full line.**
  - Required: 8 fetches.
  - Required: every `data_we` pulse has `data_wbe` = 4'h0.
